// File: rtl/inport_req_ctrl_pkg.sv
// Shared definitions for the input-port request controller: port range, flit type codes,
// field positions and FSM state encodings.
package inport_req_ctrl_pkg;

  localparam int unsigned PORT    = 4;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned DST_LSB = 0;
  localparam int unsigned DST_W   = 3;

  localparam logic [DST_W-1:0] MAX_DST = DST_W'(PORT);

  localparam logic [TYPE_W-1:0] FT_BODY   = 2'b00;
  localparam logic [TYPE_W-1:0] FT_HEAD   = 2'b01;
  localparam logic [TYPE_W-1:0] FT_TAIL   = 2'b10;
  localparam logic [TYPE_W-1:0] FT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StSend = 2'b10,
    StDrop = 2'b11
  } state_e;

  function automatic logic is_head(input logic [TYPE_W-1:0] t);
    return (t == FT_HEAD) || (t == FT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [TYPE_W-1:0] t);
    return (t == FT_TAIL) || (t == FT_SINGLE);
  endfunction

endpackage

// File: rtl/inport_req_ctrl_flit_fifo.sv
// Synchronous flit FIFO; full/empty come from read/write pointers carrying an extra wrap bit.
module flit_fifo #(
  parameter int unsigned FLIT_W = 34,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] wdata,
  output logic [FLIT_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/inport_req_ctrl.sv
// Input-port controller: buffers flits, requests the head packet's output and forwards on grant.
// Define WAIT_CNT_EN to add the wait_cnt output (per-packet arbitration wait cycles).
module inport_req_ctrl
  import inport_req_ctrl_pkg::*;
#(
  parameter int unsigned FLIT_W = 34,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PORT:0]     req,
  input  logic [PORT:0]     grt,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef WAIT_CNT_EN
  output logic [15:0]       wait_cnt,
`endif
  output logic              err
);

  state_e            st_q, st_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic              err_q, err_d;
  logic              push, pop, full, empty;
  logic [FLIT_W-1:0] head;
  logic [TYPE_W-1:0] head_type;
  logic [DST_W-1:0]  head_dst;
  logic              granted;

  flit_fifo #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_ (rst_),
    .push (push),
    .pop  (pop),
    .wdata(in_flit),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign head_type = head[FLIT_W-1 -: TYPE_W];
  assign head_dst  = head[DST_LSB +: DST_W];
  assign out_flit  = head;
  assign in_ready  = !full && !rst_;
  assign push      = in_valid && in_ready;
  assign granted   = grt[dst_q];
  assign err       = err_q;

  // Request decodes registered state only, so it never depends on the grant.
  always_comb begin
    req = '0;
    if (st_q == StReq || st_q == StSend) req[dst_q] = 1'b1;
  end

  always_comb begin
    st_d      = st_q;
    dst_d     = dst_q;
    err_d     = err_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (!empty) begin
          if (is_head(head_type)) begin
            if (head_dst <= MAX_DST) begin
              dst_d = head_dst;
              st_d  = StReq;
            end else begin
              err_d = 1'b1;
              st_d  = StDrop;
            end
          end else begin
            // Stray body/tail with no packet open: discard it.
            err_d = 1'b1;
            pop   = 1'b1;
          end
        end
      end
      StReq: begin
        if (granted) st_d = StSend;
      end
      StSend: begin
        out_valid = !empty && granted;
        pop       = out_valid && out_ready;
        if (pop && is_tail(head_type)) st_d = StIdle;
      end
      StDrop: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_tail(head_type)) st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
    if (rst_) begin
      out_valid = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      st_q  <= StIdle;
      dst_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      dst_q <= dst_d;
      err_q <= err_d;
    end
  end

`ifdef WAIT_CNT_EN
  logic [15:0] wait_q;
  logic        waiting;

  assign waiting  = (st_q == StReq) || (st_q == StSend && !granted && !empty);
  assign wait_cnt = wait_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      wait_q <= '0;
    end else if (st_q == StIdle && st_d == StReq) begin
      wait_q <= '0;
    end else if (waiting && wait_q != 16'hFFFF) begin
      wait_q <= wait_q + 16'd1;
    end
  end
`endif

endmodule
